// File: rtl/mmio_pipe_controller.sv
// mmio_pipe_controller
// --------------------
// Bridges a single-outstanding MMIO master onto an array of N_SLOT slave
// slots. A request is decoded into a slot index and a per-slot register
// address, latched, and presented to the selected slot until that slot
// acknowledges. The result is returned to the master with a one-cycle
// mmio_ready pulse (plus mmio_err on a malformed request or a timeout).
//
// Optional feature macro: MMIO_TIMEOUT_EN
//   defined   -> an ACCESS that waits TMO_CYC cycles without ack ends with
//                mmio_err=1 and mmio_rd_data=0xDEADBEEF (truncated to DW).
//   undefined -> ACCESS waits for the ack indefinitely.
//
// Ports
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   mmio_cs/rd/wr        : request select and operation (exactly one of rd/wr)
//   mmio_addr[20:0]      : word address {ignored, slot, reg}
//   mmio_wr_data         : write data
//   mmio_rd_data         : read result, held until the next completion
//   mmio_ready/mmio_err  : completion / error pulse (one cycle)
//   busy                 : transaction in flight (ACCESS or DONE)
//   slot_cs_array        : one-hot slot select
//   slot_mem_rd/wr_array : per-slot read / write strobes
//   slot_reg_addr        : register address, broadcast to all slots
//   slot_wr_data         : write data, broadcast to all slots
//   slot_rd_data_array   : slot i read data at [i*DW +: DW]
//   slot_ack_array       : per-slot completion
//
// Every output is driven from a register that is loaded with the value it
// must have in the next state, so outputs line up with the FSM state cycle.

module mmio_pipe_controller #(
    parameter int N_SLOT  = 64,
    parameter int REG_AW  = 5,
    parameter int DW      = 32,
    parameter int TMO_CYC = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mmio_cs,
    input  logic                   mmio_rd,
    input  logic                   mmio_wr,
    input  logic [20:0]            mmio_addr,
    input  logic [DW-1:0]          mmio_wr_data,
    output logic [DW-1:0]          mmio_rd_data,
    output logic                   mmio_ready,
    output logic                   mmio_err,
    output logic                   busy,
    output logic [N_SLOT-1:0]      slot_cs_array,
    output logic [N_SLOT-1:0]      slot_mem_rd_array,
    output logic [N_SLOT-1:0]      slot_mem_wr_array,
    output logic [REG_AW-1:0]      slot_reg_addr,
    output logic [DW-1:0]          slot_wr_data,
    input  logic [N_SLOT*DW-1:0]   slot_rd_data_array,
    input  logic [N_SLOT-1:0]      slot_ack_array
);

    localparam int SAW = $clog2(N_SLOT);
    localparam int CW  = 16;
    localparam logic [CW-1:0] TMO_LIM  = CW'(TMO_CYC);
`ifdef MMIO_TIMEOUT_EN
    localparam logic [DW-1:0] TMO_DATA = DW'(32'hDEADBEEF);
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic logic [N_SLOT-1:0] f_onehot(input logic [SAW-1:0] idx);
        f_onehot = {{(N_SLOT-1){1'b0}}, 1'b1} << idx;
    endfunction

    state_t              r_state, w_state_nxt;

    // transaction latches
    logic [SAW-1:0]      r_slot, w_slot_nxt;
    logic [REG_AW-1:0]   r_reg, w_reg_nxt;
    logic                r_op_wr, w_op_wr_nxt;
    logic [DW-1:0]       r_wdata, w_wdata_nxt;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;

    // output registers and their next values
    logic [DW-1:0]       r_rd_data, w_rd_data_nxt;
    logic                r_ready, w_ready_nxt;
    logic                r_err, w_err_nxt;
    logic                r_busy, w_busy_nxt;
    logic [N_SLOT-1:0]   r_cs, w_cs_nxt;
    logic [N_SLOT-1:0]   r_mrd, w_mrd_nxt;
    logic [N_SLOT-1:0]   r_mwr, w_mwr_nxt;
    logic [REG_AW-1:0]   r_sreg, w_sreg_nxt;
    logic [DW-1:0]       r_swd, w_swd_nxt;

    logic [SAW-1:0]      w_req_slot;
    logic [REG_AW-1:0]   w_req_reg;
    logic                w_ack;
    logic [DW-1:0]       w_slot_rdata;
    logic [CW-1:0]       w_cnt_inc;
    logic                w_unused_addr;

    assign w_req_slot    = mmio_addr[REG_AW+SAW-1:REG_AW];
    assign w_req_reg     = mmio_addr[REG_AW-1:0];
    assign w_unused_addr = &{1'b0, mmio_addr[20:REG_AW+SAW]};

    // Only the latched slot's ack and data matter; other slots are ignored.
    assign w_ack        = slot_ack_array[r_slot];
    assign w_slot_rdata = slot_rd_data_array[int'(r_slot)*DW +: DW];

    // The counter parks at TMO_CYC so it never wraps during a long wait.
    assign w_cnt_inc = (r_cnt == TMO_LIM) ? r_cnt : r_cnt + 16'd1;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, latch and output-next logic
    always_comb begin
        w_state_nxt   = r_state;
        w_slot_nxt    = r_slot;
        w_reg_nxt     = r_reg;
        w_op_wr_nxt   = r_op_wr;
        w_wdata_nxt   = r_wdata;
        w_cnt_nxt     = r_cnt;
        w_rd_data_nxt = r_rd_data;
        w_err_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (mmio_cs && (mmio_rd != mmio_wr)) begin
                    w_state_nxt = ST_ACCESS;
                    w_slot_nxt  = w_req_slot;
                    w_reg_nxt   = w_req_reg;
                    w_op_wr_nxt = mmio_wr;
                    w_wdata_nxt = mmio_wr_data;
                    w_cnt_nxt   = {CW{1'b0}};
                end else if (mmio_cs && mmio_rd && mmio_wr) begin
                    // Malformed request: report it without touching any slot.
                    w_state_nxt = ST_DONE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // An ack in the same cycle as the timeout wins.
                if (w_ack) begin
                    w_state_nxt   = ST_DONE;
                    w_rd_data_nxt = r_op_wr ? {DW{1'b0}} : w_slot_rdata;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
`ifdef MMIO_TIMEOUT_EN
                    if (w_cnt_inc == TMO_LIM) begin
                        w_state_nxt   = ST_DONE;
                        w_err_nxt     = 1'b1;
                        w_rd_data_nxt = TMO_DATA;
                    end else begin
                        w_state_nxt = ST_ACCESS;
                    end
`else
                    w_state_nxt = ST_ACCESS;
`endif
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Slot-side outputs are live only while the next state is ACCESS.
        if (w_state_nxt == ST_ACCESS) begin
            w_cs_nxt   = f_onehot(w_slot_nxt);
            w_mrd_nxt  = w_op_wr_nxt ? {N_SLOT{1'b0}} : f_onehot(w_slot_nxt);
            w_mwr_nxt  = w_op_wr_nxt ? f_onehot(w_slot_nxt) : {N_SLOT{1'b0}};
            w_sreg_nxt = w_reg_nxt;
            w_swd_nxt  = w_wdata_nxt;
        end else begin
            w_cs_nxt   = {N_SLOT{1'b0}};
            w_mrd_nxt  = {N_SLOT{1'b0}};
            w_mwr_nxt  = {N_SLOT{1'b0}};
            w_sreg_nxt = {REG_AW{1'b0}};
            w_swd_nxt  = {DW{1'b0}};
        end

        w_ready_nxt = (w_state_nxt == ST_DONE);
        w_busy_nxt  = (w_state_nxt != ST_IDLE);
    end

    // Transaction latches and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot    <= {SAW{1'b0}};
            r_reg     <= {REG_AW{1'b0}};
            r_op_wr   <= 1'b0;
            r_wdata   <= {DW{1'b0}};
            r_cnt     <= {CW{1'b0}};
            r_rd_data <= {DW{1'b0}};
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_cs      <= {N_SLOT{1'b0}};
            r_mrd     <= {N_SLOT{1'b0}};
            r_mwr     <= {N_SLOT{1'b0}};
            r_sreg    <= {REG_AW{1'b0}};
            r_swd     <= {DW{1'b0}};
        end else begin
            r_slot    <= w_slot_nxt;
            r_reg     <= w_reg_nxt;
            r_op_wr   <= w_op_wr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rd_data <= w_rd_data_nxt;
            r_ready   <= w_ready_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= w_busy_nxt;
            r_cs      <= w_cs_nxt;
            r_mrd     <= w_mrd_nxt;
            r_mwr     <= w_mwr_nxt;
            r_sreg    <= w_sreg_nxt;
            r_swd     <= w_swd_nxt;
        end
    end

    assign mmio_rd_data      = r_rd_data;
    assign mmio_ready        = r_ready;
    assign mmio_err          = r_err;
    assign busy              = r_busy;
    assign slot_cs_array     = r_cs;
    assign slot_mem_rd_array = r_mrd;
    assign slot_mem_wr_array = r_mwr;
    assign slot_reg_addr     = r_sreg;
    assign slot_wr_data      = r_swd;

endmodule
